// File: rtl/mm2st_pkg.sv
// mm2st_pkg: shared CSR map, control bit positions, FSM states and byte swap helper
package mm2st_pkg;

    localparam logic [1:0] CSR_START_ADDR = 2'd0;
    localparam logic [1:0] CSR_LENGTH     = 2'd1;
    localparam logic [1:0] CSR_CONTROL    = 2'd2;
    localparam logic [1:0] CSR_STATUS     = 2'd3;

    localparam int CTRL_GO       = 0;
    localparam int CTRL_SWAP     = 1;
    localparam int CTRL_CLR_DONE = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; head word is visible on rdata while not empty
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot this cycle, so a full FIFO can still take a simultaneous push
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        empty   = count == '0;
        full    = count == (AW + 1)'(DEPTH);
        rdata   = mem[rd_ptr];
    end

    // Storage array, no reset needed since contents are only read when count says so
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/mm2st_read_master.sv
// mm2st_read_master: CSR-controlled Avalon-MM burst-free read master feeding an Avalon-ST source
module mm2st_read_master
    import mm2st_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        aso_valid,
    output logic [31:0] aso_data,
    input  logic        aso_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t           state;
    logic [31:0]      start_addr;
    logic [31:0]      addr;
    logic [LEN_W-1:0] length;
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] received;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    fifo_count;
    logic             swap;
    logic             done;
    logic [15:0]      words_sent;
    logic             fifo_empty;
    logic             fifo_full;
    logic [31:0]      fifo_head;
    logic             go;
    logic             clr_done;
    logic             credit;
    logic             accept;
    logic             beat;
    logic             push;
    logic             pop;
    logic [31:0]      rd_mux;

    // Request/stream handshakes; credit counts in-flight reads against free FIFO space
    always_comb begin
        go                = avs_write && avs_address == CSR_CONTROL && avs_writedata[CTRL_GO];
        clr_done          = avs_write && avs_address == CSR_CONTROL && avs_writedata[CTRL_CLR_DONE];
        credit            = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH);
        avm_read          = state == READ && issued < len_cnt && credit;
        avm_address       = addr;
        accept            = avm_read && !avm_waitrequest;
        beat              = avm_readdatavalid && state != IDLE;
        push              = beat && !fifo_full;
        aso_valid         = !fifo_empty;
        pop               = aso_valid && aso_ready;
        aso_data          = swap ? byte_swap32(fifo_head) : fifo_head;
        rd_mux            = avs_address == CSR_START_ADDR ? start_addr :
                            avs_address == CSR_LENGTH     ? 32'(length) :
                            avs_address == CSR_CONTROL    ? {30'd0, swap, 1'b0} :
                                                            {words_sent, 14'd0, done, state != IDLE};
    end

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (avm_readdata),
        .pop     (pop),
        .rdata   (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Software-visible configuration; working copies are only taken at GO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_addr <= '0;
            length     <= '0;
            swap       <= 1'b0;
        end else if (avs_write) begin
            if (avs_address == CSR_START_ADDR) start_addr <= {avs_writedata[31:2], 2'b00};
            if (avs_address == CSR_LENGTH) length <= avs_writedata[LEN_W-1:0];
            if (avs_address == CSR_CONTROL) swap <= avs_writedata[CTRL_SWAP];
        end
    end

    // CSR read port: one-cycle registered read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_mux;
        end
    end

    // Transfer FSM with its address, issue/receive/outstanding counters and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr        <= '0;
            len_cnt     <= '0;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            done        <= 1'b0;
            words_sent  <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(beat);
            if (beat) received <= received + 1'b1;
            if (accept) begin
                addr   <= addr + 32'd4;
                issued <= issued + 1'b1;
            end
            if (pop) words_sent <= words_sent + 1'b1;
            if (clr_done) done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        addr        <= start_addr;
                        len_cnt     <= length;
                        issued      <= '0;
                        received    <= '0;
                        outstanding <= '0;
                        words_sent  <= '0;
                        done        <= length == '0;
                        state       <= length == '0 ? IDLE : READ;
                    end
                end
                READ: begin
                    if (accept && issued + 1'b1 == len_cnt) state <= DRAIN;
                end
                DRAIN: begin
                    if (received == len_cnt && fifo_empty) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm2st_read_master.sv
// tb_mm2st_read_master: directed bench with a latency-modelling memory slave and stream monitor
module tb_mm2st_read_master;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        aso_valid;
    logic [31:0] aso_data;
    logic        aso_ready;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issue_cnt = 0;
    int          rx_cnt = 0;
    logic [31:0] issue_addr = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] last_data = '0;
    logic        rand_wait = 1'b0;
    logic        mon_swap = 1'b0;

    typedef struct {
        logic [31:0] a;
        int          rt;
    } rsp_t;
    rsp_t rsp_q[$];

    mm2st_read_master #(
        .FIFO_DEPTH (16),
        .LEN_W      (16)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .aso_valid         (aso_valid),
        .aso_data          (aso_data),
        .aso_ready         (aso_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h1122_3344;
            32'h0000_1004: return 32'h5566_7788;
            32'h0000_1008: return 32'h99AA_BBCC;
            32'h0000_100C: return 32'hDDEE_FF00;
            32'h0000_2000: return 32'h9001_0000;
            default:       return {~a[15:0], a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        chk("csr_rdvalid", {31'd0, avs_readdatavalid}, 32'd1);
        d = avs_readdata;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] len, input logic [31:0] ctrl);
        issue_addr = a;
        exp_addr   = a;
        issue_cnt  = 0;
        rx_cnt     = 0;
        csr_wr(2'd0, a);
        csr_wr(2'd1, len);
        csr_wr(2'd2, ctrl);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("rx_count", rx_cnt, n);
    endtask

    // Memory slave with in-order responses after a 1..6 cycle latency, plus stream monitor
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_addr = '0;
        int          last_rt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                rsp_q.delete();
                avm_readdatavalid = 1'b0;
                avm_readdata      = '0;
                avm_waitrequest   = 1'b0;
                prev_stall        = 1'b0;
                last_rt           = 0;
            end else begin
                if (rsp_q.size() > 0 && rsp_q[0].rt <= cyc) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = mem_val(rsp_q[0].a);
                    void'(rsp_q.pop_front());
                end else begin
                    avm_readdatavalid = 1'b0;
                    avm_readdata      = '0;
                end
                avm_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
                #1;
                if (prev_stall) begin
                    chk("hold_read", {31'd0, avm_read}, 32'd1);
                    chk("hold_addr", avm_address, prev_addr);
                end
                prev_stall = avm_read && avm_waitrequest;
                prev_addr  = avm_address;
                if (avm_read && !avm_waitrequest) begin
                    int lat;
                    int rt;
                    chk("avm_address", avm_address, issue_addr);
                    issue_addr = issue_addr + 32'd4;
                    issue_cnt++;
                    lat = rand_wait ? int'($urandom_range(1, 6)) : 1;
                    rt  = (cyc + lat > last_rt + 1) ? cyc + lat : last_rt + 1;
                    last_rt = rt;
                    rsp_q.push_back('{a: avm_address, rt: rt});
                end
                if (aso_valid && aso_ready) begin
                    chk("aso_data", aso_data, mon_swap ? swap32(mem_val(exp_addr)) : mem_val(exp_addr));
                    last_data = aso_data;
                    exp_addr  = exp_addr + 32'd4;
                    rx_cnt++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        reset_n           = 1'b0;
        avs_address       = '0;
        avs_write         = 1'b0;
        avs_writedata     = '0;
        avs_read          = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        aso_ready         = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Reset state of outputs and every CSR
        chk("rst_aso_valid", {31'd0, aso_valid}, 32'd0);
        chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
        chk("rst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            csr_rd(2'(a), d);
            chk("rst_csr", d, 32'd0);
        end
        tick(1);
        chk("rdvalid_drop", {31'd0, avs_readdatavalid}, 32'd0);
        csr_wr(2'd0, 32'h0000_1003);
        csr_rd(2'd0, d);
        chk("start_lsb_zero", d, 32'h0000_1000);
        csr_wr(2'd1, 32'hFFFF_0004);
        csr_rd(2'd1, d);
        chk("length_mask", d, 32'h0000_0004);

        // Four-word transfer with the known memory table
        aso_ready = 1'b1;
        start(32'h1000, 32'd4, 32'h1);
        chk("go_latency", {31'd0, avm_read}, 32'd1);
        wait_rx(4, 100);
        chk("last_word", last_data, 32'hDDEE_FF00);
        chk("issue4", issue_cnt, 32'd4);
        tick(3);
        csr_rd(2'd3, d);
        chk("status4", d, 32'h0004_0002);
        csr_rd(2'd2, d);
        chk("go_selfclear", d, 32'h0);

        // Byte swap of a single word, then CLR_DONE
        mon_swap = 1'b1;
        start(32'h2000, 32'd1, 32'h3);
        wait_rx(1, 50);
        chk("swap_word", last_data, 32'h0000_0190);
        tick(3);
        csr_rd(2'd3, d);
        chk("status_swap", d, 32'h0001_0002);
        csr_wr(2'd2, 32'h8);
        mon_swap = 1'b0;
        csr_rd(2'd3, d);
        chk("clr_done", d, 32'h0001_0000);
        csr_rd(2'd2, d);
        chk("swap_off", d, 32'h0);

        // Back-pressure: credit stops issue at FIFO depth
        aso_ready = 1'b0;
        start(32'h5000, 32'd40, 32'h1);
        tick(60);
        chk("credit_issue", issue_cnt, 32'd16);
        chk("credit_read_low", {31'd0, avm_read}, 32'd0);
        chk("bp_valid", {31'd0, aso_valid}, 32'd1);
        aso_ready = 1'b1;
        wait_rx(40, 400);
        chk("issue40", issue_cnt, 32'd40);
        tick(3);
        csr_rd(2'd3, d);
        chk("status40", d, 32'h0028_0002);

        // Random waitrequest and variable read latency
        rand_wait = 1'b1;
        start(32'h8000, 32'd100, 32'h1);
        wait_rx(100, 3000);
        chk("issue100", issue_cnt, 32'd100);
        tick(10);
        rand_wait = 1'b0;
        tick(2);
        csr_rd(2'd3, d);
        chk("status100", d, 32'h0064_0002);

        // Zero length: done without any read
        start(32'h1000, 32'd0, 32'h1);
        tick(5);
        chk("len0_issue", issue_cnt, 32'd0);
        csr_rd(2'd3, d);
        chk("len0_status", d, 32'h0000_0002);

        // Second GO while busy is ignored
        start(32'h3000, 32'd8, 32'h1);
        tick(2);
        csr_wr(2'd0, 32'h6000);
        csr_wr(2'd1, 32'd2);
        csr_wr(2'd2, 32'h1);
        wait_rx(8, 200);
        chk("issue8", issue_cnt, 32'd8);
        tick(3);
        csr_rd(2'd3, d);
        chk("status8", d, 32'h0008_0002);
        csr_rd(2'd0, d);
        chk("start_written", d, 32'h0000_6000);

        // Reset in the middle of a transfer, then a fresh transfer
        aso_ready = 1'b0;
        start(32'h1000, 32'd40, 32'h1);
        tick(5);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_aso_valid", {31'd0, aso_valid}, 32'd0);
        chk("mid_rst_avm_read", {31'd0, avm_read}, 32'd0);
        chk("mid_rst_avm_addr", avm_address, 32'd0);
        chk("mid_rst_readdata", avs_readdata, 32'd0);
        chk("mid_rst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(2);
        csr_rd(2'd3, d);
        chk("post_rst_status", d, 32'h0);
        csr_rd(2'd1, d);
        chk("post_rst_length", d, 32'h0);
        aso_ready = 1'b1;
        start(32'h1000, 32'd3, 32'h1);
        wait_rx(3, 100);
        chk("post_rst_last", last_data, 32'h99AA_BBCC);
        tick(3);
        csr_rd(2'd3, d);
        chk("post_rst_done", d, 32'h0003_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mm2st_read_master.md
Name: mm2st_read_master

Overview:
- Memory-to-stream read engine: Avalon-MM read master fetches LENGTH consecutive 32-bit words from START_ADDR.
- Buffers the read data in an internal FIFO and emits each word on an Avalon-ST source.
- Sits upstream of the stream processing blocks; supplies their Avalon-ST sink.
- Controlled by a 4-register Avalon-MM slave CSR with 1-cycle read latency.

Parameters:
- FIFO_DEPTH, 16, read-data buffer depth in words; power of 2, minimum 4.
- LEN_W, 16, width of the word-count registers and counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  2  CSR index
- avs_write  in  1  CSR write strobe
- avs_writedata  in  32  CSR write data
- avs_read  in  1  CSR read strobe
- avs_readdata  out  32  CSR read data, registered
- avs_readdatavalid  out  1  asserted 1 cycle after avs_read
- avm_address  out  32  byte address, word aligned
- avm_read  out  1  read request
- avm_waitrequest  in  1  request stall
- avm_readdata  in  32  returned word
- avm_readdatavalid  in  1  returned word valid
- aso_valid  out  1  stream data valid
- aso_data  out  32  stream data
- aso_ready  in  1  downstream accept

Behaviour:

Reset:
- Every output and register is 0; the FSM is in IDLE and the FIFO is empty.
- Reset asserted mid-transfer abandons the transfer. Outstanding reads are dropped. readdatavalid arriving after reset release is ignored while in IDLE.

CSR map:
- 0 START_ADDR: RW; bits[1:0] read as 0.
- 1 LENGTH: RW [LEN_W-1:0]; other bits read as 0.
- 2 CONTROL:
  - Write bit0 = GO (self-clearing pulse, reads as 0); bit1 = SWAP (RW).
  - Write bit3 = CLR_DONE.
- 3 STATUS: RO {words_sent[15:0], 14'b0, done, busy}.
- avs_readdatavalid equals avs_read delayed one cycle. Readdata is registered at the read cycle.

FSM states:
- IDLE: GO latches START_ADDR and LENGTH into working counters and clears done.
  - LENGTH = 0: done is set next cycle; the FSM stays in IDLE and issues no reads.
  - LENGTH ≠ 0: go to READ; busy = 1.
- READ: avm_read is asserted while issued < len and credit is available.
  - A request is accepted when avm_read && !avm_waitrequest. On accept, the address increments by 4 and issued increments.
  - avm_read and avm_address stay stable while waitrequest is high.
  - When issued = len, go to DRAIN.
- DRAIN: when received = len, the FIFO is empty and no beat is pending, set done = 1, busy = 0 and go to IDLE.
- GO while busy is ignored. CSR writes to START_ADDR or LENGTH while busy take effect at the next GO.

Credit:
- outstanding = accepted reads minus readdatavalid beats.
- Issue only if fifo_count + outstanding < FIFO_DEPTH, so the FIFO never overflows.
- Accept and return in the same cycle leave outstanding unchanged.

Stream output:
- Each readdatavalid beat is written to the FIFO.
- The FIFO is first-word-fall-through, so aso_valid rises the cycle after the beat.
- aso_valid = !fifo_empty. Pop on aso_valid && aso_ready.
- aso_data = FIFO head, byte-reversed when SWAP = 1 (e.g. 0x90010000 -> 0x00000190).
- SWAP is sampled combinationally; software changes it only in IDLE.
- words_sent increments per pop, clears on GO and wraps at 2^16.
- Throughput: 1 word/cycle when waitrequest = 0, aso_ready = 1 and read latency is ≤ FIFO_DEPTH.

Latency:
- GO write at cycle t: avm_read is first high at t+1.

Decomposition:
- Package mm2st_pkg:
  - CSR address constants.
  - CONTROL bit indices.
  - FSM state enum (IDLE, READ, DRAIN).
  - byte_swap32 function.
- Sub-module sync_fifo_fwft (parameter DEPTH, WIDTH):
  - Write/read ports plus count, empty and full outputs.
  - Simultaneous push and pop on a full or empty FIFO is legal.

Test Plan:
1. Reset, then read every CSR -> all values 0 and avs_readdatavalid one cycle after each read; aso_valid = 0 and avm_read = 0.
2. Memory at 0x1000 = {0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00}; START_ADDR = 0x1000, LENGTH = 4, GO, aso_ready = 1 -> addresses 0x1000/04/08/0C; 4 beats in order; STATUS = 0x00040002.
3. SWAP = 1, one word 0x90010000 -> aso_data = 0x00000190; done set.
4. LENGTH = 40, aso_ready = 0 -> exactly 16 reads accepted and avm_read then low; raise aso_ready -> all 40 words delivered in order with no overflow.
5. Random waitrequest plus read latency of 1–6 cycles, LENGTH = 100 -> each address issued exactly once; output order matches memory; no gaps in data.
6. LENGTH = 0 GO -> done with no avm_read. Second GO issued mid-transfer -> ignored. Reset mid-READ -> all outputs 0 and a fresh GO works.
